multicycle_control: RTL

- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq and j.
- Drives datapath mux selects and write enables, and drives the 2-bit ALUOp consumed by the ALU-control decoder.
- Stalls on a ready handshake from the shared instruction/data memory.

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_next_state.sv | 63 ++++++
 rtl/multicycle_control.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Optional ADDI states are built when MC_ADDI_EN is defined.
package mc_pkg;

    localparam int SW = 4;

    typedef enum logic [SW-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
`ifdef MC_ADDI_EN
        ,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] ASB_RT     = 2'd0;
    localparam logic [1:0] ASB_FOUR   = 2'd1;
    localparam logic [1:0] ASB_IMM    = 2'd2;
    localparam logic [1:0] ASB_IMM_SH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state logic for the multicycle control FSM.
// Opcode 8 decodes to the ADDI path only when MC_ADDI_EN is defined.
module mc_next_state
    import mc_pkg::*;
#(
    parameter int OPW = 6
) (
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] op_q,
    input  logic           mem_ready,
    output state_t         next,
    output logic           illegal
);

    always_comb begin
        next    = S_FETCH;
        illegal = 1'b0;
        unique case (state)
            S_FETCH:
                next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    opcode == OPW'(OP_RTYPE): next = S_EXECUTE;
                    opcode == OPW'(OP_LW):    next = S_MEM_ADDR;
                    opcode == OPW'(OP_SW):    next = S_MEM_ADDR;
                    opcode == OPW'(OP_BEQ):   next = S_BRANCH;
                    opcode == OPW'(OP_J):     next = S_JUMP;
`ifdef MC_ADDI_EN
                    opcode == OPW'(OP_ADDI):  next = S_ADDI_EX;
`endif
                    default:                  illegal = 1'b1;
                endcase
            end
            // Load/store split uses the opcode captured in DECODE.
            S_MEM_ADDR:
                next = (op_q == OPW'(OP_LW)) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:
                next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:
                next = S_FETCH;
            S_MEM_WRITE:
                next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:
                next = S_R_WB;
            S_R_WB:
                next = S_FETCH;
            S_BRANCH:
                next = S_FETCH;
            S_JUMP:
                next = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDI_EX:
                next = S_ADDI_WB;
            S_ADDI_WB:
                next = S_FETCH;
`endif
            default:
                next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Build with MC_ADDI_EN to add the ADDI_EX/ADDI_WB states.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [OPW-1:0] Opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSource,
    output logic           illegal_op,
    output logic [STW-1:0] state_dbg
);

    state_t         state;
    state_t         next;
    logic [OPW-1:0] op_q;
    logic           illegal;
    ctrl_t          raw;
    ctrl_t          ctrl;

    mc_next_state #(
        .OPW(OPW)
    ) u_next (
        .state    (state),
        .opcode   (Opcode),
        .op_q     (op_q),
        .mem_ready(mem_ready),
        .next     (next),
        .illegal  (illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= next;
            if (state == S_DECODE)
                op_q <= Opcode;
        end
    end

    always_comb begin
        raw = '0;
        unique case (state)
            S_FETCH: begin
                raw.mem_read  = 1'b1;
                raw.alu_src_b = ASB_FOUR;
                raw.alu_op    = ALUOP_ADD;
                raw.pc_source = PCS_ALU;
                raw.ir_write  = mem_ready;
                raw.pc_write  = mem_ready;
            end
            // Speculative branch target while the opcode is decoded.
            S_DECODE: begin
                raw.alu_src_b = ASB_IMM_SH;
                raw.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                raw.alu_src_a = 1'b1;
                raw.alu_src_b = ASB_IMM;
                raw.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                raw.mem_read = 1'b1;
                raw.iord     = 1'b1;
            end
            S_MEM_WB: begin
                raw.reg_write  = 1'b1;
                raw.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                raw.mem_write = 1'b1;
                raw.iord      = 1'b1;
            end
            S_EXECUTE: begin
                raw.alu_src_a = 1'b1;
                raw.alu_src_b = ASB_RT;
                raw.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                raw.reg_write = 1'b1;
                raw.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                raw.alu_src_a     = 1'b1;
                raw.alu_src_b     = ASB_RT;
                raw.alu_op        = ALUOP_SUB;
                raw.pc_write_cond = 1'b1;
                raw.pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                raw.pc_write  = 1'b1;
                raw.pc_source = PCS_JUMP;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EX: begin
                raw.alu_src_a = 1'b1;
                raw.alu_src_b = ASB_IMM;
                raw.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                raw.reg_write = 1'b1;
            end
`endif
            default: raw = '0;
        endcase
    end

    // Reset forces every output low, not just the state.
    assign ctrl = reset_n ? raw : '0;

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;

    assign illegal_op = reset_n & illegal;
    assign state_dbg  = reset_n ? STW'(state) : '0;

endmodule
